// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared FSM encoding, width derivations and saturation helper for the CNN pipeline
package cnn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_RES  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SAT_PASS = 2'd0,
        SAT_MAX  = 2'd1,
        SAT_MIN  = 2'd2
    } sat_t;

    // Wide enough for any accumulator this package's users derive.
    localparam int SAT_W = 128;

    function automatic int calc_accw(input int dataw, input int ch_in);
        return 2 * dataw + $clog2(ch_in + 1);
    endfunction

    function automatic int calc_cfg_aw(input int ch_out, input int ch_in);
        return $clog2(ch_out * (ch_in + 1));
    endfunction

    // Reports which bound of a dataw-bit signed range v falls outside, if any.
    function automatic sat_t sat_signed(input logic signed [SAT_W-1:0] v, input int dataw);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (128'sd1 <<< (dataw - 1)) - 128'sd1;
        lo = -hi - 128'sd1;
        if (v > hi) return SAT_MAX;
        if (v < lo) return SAT_MIN;
        return SAT_PASS;
    endfunction

endpackage

// File: rtl/conv_mac_sat.sv
// rtl/conv_mac_sat.sv - one output channel: accumulator, MAC and sat/ReLU result stage (CONV1X1_RELU_EN)
module conv_mac_sat
    import cnn_pkg::*;
#(
    parameter int DATAW     = 32,
    parameter int FRAC_BITS = 0,
    parameter int ACCW      = calc_accw(32, 4)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_init,
    input  logic                    i_mac_en,
    input  logic                    i_res_en,
    input  logic signed [DATAW-1:0] i_bias,
    input  logic signed [DATAW-1:0] i_data,
    input  logic signed [DATAW-1:0] i_weight,
    output logic        [DATAW-1:0] o_data
);
    localparam int PW = 2 * DATAW;

    logic signed [ACCW-1:0]  r_acc;
    logic signed [PW-1:0]    w_prod;
    logic signed [ACCW-1:0]  w_bias_ext;
    logic signed [ACCW-1:0]  w_shifted;
    logic signed [SAT_W-1:0] w_wide;
    sat_t                    w_sat;
    logic        [DATAW-1:0] w_clip;
    logic        [DATAW-1:0] w_res;

    assign w_prod     = PW'(i_data) * PW'(i_weight);
    assign w_bias_ext = {{(ACCW-DATAW){i_bias[DATAW-1]}}, i_bias} <<< FRAC_BITS;
    assign w_shifted  = r_acc >>> FRAC_BITS;
    assign w_wide     = {{(SAT_W-ACCW){w_shifted[ACCW-1]}}, w_shifted};
    assign w_sat      = sat_signed(w_wide, DATAW);

    always_comb begin
        w_clip = w_shifted[DATAW-1:0];
        case (w_sat)
            SAT_MAX: w_clip = {1'b0, {(DATAW-1){1'b1}}};
            SAT_MIN: w_clip = {1'b1, {(DATAW-1){1'b0}}};
            default: w_clip = w_shifted[DATAW-1:0];
        endcase
    end

`ifdef CONV1X1_RELU_EN
    assign w_res = w_clip[DATAW-1] ? '0 : w_clip;
`else
    assign w_res = w_clip;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc  <= '0;
            o_data <= '0;
        end else begin
            if (i_init) begin
                r_acc <= w_bias_ext;
            end else if (i_mac_en) begin
                r_acc <= r_acc + {{(ACCW-PW){w_prod[PW-1]}}, w_prod};
            end
            if (i_res_en) begin
                o_data <= w_res;
            end
        end
    end

endmodule

// File: rtl/conv2d_1x1_seq_layer.sv
// rtl/conv2d_1x1_seq_layer.sv - pointwise conv layer top: FSM, cfg register file, input latch, pixel counter (CONV1X1_RELU_EN)
module conv2d_1x1_seq_layer
    import cnn_pkg::*;
#(
    parameter int CH_IN     = 4,
    parameter int CH_OUT    = 4,
    parameter int DATAW     = 32,
    parameter int FRAC_BITS = 0,
    parameter int IMG_W     = 3,
    parameter int IMG_H     = 3,
    localparam int CFG_AW   = calc_cfg_aw(CH_OUT, CH_IN)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CH_IN*DATAW-1:0]   in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CH_OUT*DATAW-1:0]  out_data,
    output logic                     out_last,
    input  logic                     cfg_we,
    input  logic [CFG_AW-1:0]        cfg_addr,
    input  logic [DATAW-1:0]         cfg_data,
    output logic                     cfg_err
);
    localparam int ACCW = calc_accw(DATAW, CH_IN);
    localparam int NCFG = CH_OUT * (CH_IN + 1);
    localparam int NPIX = IMG_W * IMG_H;
    localparam int CHW  = (CH_IN > 1) ? $clog2(CH_IN) : 1;
    localparam int PIXW = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [CFG_AW:0] NCFG_V   = (CFG_AW+1)'(NCFG);
    localparam logic [CHW-1:0]  CH_LAST  = CHW'(CH_IN - 1);
    localparam logic [PIXW-1:0] PIX_LAST = PIXW'(NPIX - 1);

    state_t                   r_state;
    logic [CHW-1:0]           r_ch;
    logic [PIXW-1:0]          r_pix_cnt;
    logic                     r_out_valid;
    logic                     r_cfg_err;
    logic signed [DATAW-1:0]  r_in   [CH_IN];
    logic signed [DATAW-1:0]  r_w    [CH_OUT][CH_IN];
    logic signed [DATAW-1:0]  r_bias [CH_OUT];

    logic w_accept;
    logic w_cfg_ok;

    assign w_accept  = (r_state == ST_IDLE) && in_valid;
    // An input accept owns the cycle, so a coincident write is refused.
    assign w_cfg_ok  = cfg_we && (r_state == ST_IDLE) && !in_valid && ({1'b0, cfg_addr} < NCFG_V);

    assign in_ready  = (r_state == ST_IDLE) && !rst;
    assign out_valid = r_out_valid;
    assign out_last  = (r_pix_cnt == PIX_LAST) && !rst;
    assign cfg_err   = r_cfg_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ch        <= '0;
            r_pix_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_cfg_err   <= 1'b0;
            for (int c = 0; c < CH_IN; c++) begin
                r_in[c] <= '0;
            end
            for (int o = 0; o < CH_OUT; o++) begin
                r_bias[o] <= '0;
                for (int c = 0; c < CH_IN; c++) begin
                    r_w[o][c] <= '0;
                end
            end
        end else begin
            r_cfg_err <= cfg_we && !w_cfg_ok;
            if (w_cfg_ok) begin
                for (int o = 0; o < CH_OUT; o++) begin
                    for (int c = 0; c < CH_IN; c++) begin
                        if (cfg_addr == CFG_AW'(o * (CH_IN + 1) + c)) r_w[o][c] <= cfg_data;
                    end
                    if (cfg_addr == CFG_AW'(o * (CH_IN + 1) + CH_IN)) r_bias[o] <= cfg_data;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        for (int c = 0; c < CH_IN; c++) begin
                            r_in[c] <= in_data[c*DATAW +: DATAW];
                        end
                        r_ch    <= '0;
                        r_state <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    r_ch <= r_ch + 1'b1;
                    if (r_ch == CH_LAST) r_state <= ST_RES;
                end
                ST_RES: begin
                    r_out_valid <= 1'b1;
                    r_state     <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_pix_cnt   <= (r_pix_cnt == PIX_LAST) ? '0 : r_pix_cnt + 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < CH_OUT; g++) begin : g_mac
        logic [DATAW-1:0] w_res;

        conv_mac_sat #(
            .DATAW     (DATAW),
            .FRAC_BITS (FRAC_BITS),
            .ACCW      (ACCW)
        ) u_mac (
            .clk      (clk),
            .rst      (rst),
            .i_init   (w_accept),
            .i_mac_en (r_state == ST_MAC),
            .i_res_en (r_state == ST_RES),
            .i_bias   (r_bias[g]),
            .i_data   (r_in[r_ch]),
            .i_weight (r_w[g][r_ch]),
            .o_data   (w_res)
        );

        assign out_data[g*DATAW +: DATAW] = w_res;
    end

endmodule

// File: tb/tb_conv2d_1x1_seq_layer.sv
// tb/tb_conv2d_1x1_seq_layer.sv - scoreboard bench for conv2d_1x1_seq_layer with a behavioural reference model
module tb_conv2d_1x1_seq_layer;
    localparam int CH_IN  = 4;
    localparam int CH_OUT = 4;
    localparam int DATAW  = 32;
    localparam int NPIX   = 9;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] out_data;
    logic         out_last;
    logic         cfg_we = 1'b0;
    logic [4:0]   cfg_addr = '0;
    logic [31:0]  cfg_data = '0;
    logic         cfg_err;

    always #5 clk = ~clk;

    conv2d_1x1_seq_layer #(
        .CH_IN(CH_IN), .CH_OUT(CH_OUT), .DATAW(DATAW), .FRAC_BITS(0), .IMG_W(3), .IMG_H(3)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err)
    );

    typedef struct {
        logic [127:0] data;
        logic         last;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   exp_pix = 0;
    logic signed [31:0] mw [4][4];
    logic signed [31:0] mb [4];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] model(input logic [127:0] px);
        logic [127:0]        r;
        logic signed [127:0] acc;
        logic signed [127:0] a;
        logic signed [127:0] b;
        logic [31:0]         res;
        r = '0;
        for (int o = 0; o < 4; o++) begin
            acc = mb[o];
            for (int i = 0; i < 4; i++) begin
                a = $signed(px[i*32 +: 32]);
                b = mw[o][i];
                acc = acc + a * b;
            end
            if (acc > 128'sd2147483647) res = 32'h7fff_ffff;
            else if (acc < -128'sd2147483648) res = 32'h8000_0000;
            else res = acc[31:0];
`ifdef CONV1X1_RELU_EN
            if (res[31]) res = '0;
`endif
            r[o*32 +: 32] = res;
        end
        return r;
    endfunction

    function automatic logic [127:0] pack4(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c, input logic [31:0] d);
        return {d, c, b, a};
    endfunction

    function automatic logic [31:0] rnd_word();
        if ($urandom_range(0, 3) == 0) return $urandom;
        return $urandom_range(0, 2000) - 1000;
    endfunction

    task automatic model_clear();
        for (int o = 0; o < 4; o++) begin
            mb[o] = '0;
            for (int i = 0; i < 4; i++) mw[o][i] = '0;
        end
        exp_pix = 0;
        q.delete();
    endtask

    task automatic push_exp(input logic [127:0] px);
        exp_t e;
        e.data = model(px);
        e.last = (exp_pix == NPIX - 1);
        q.push_back(e);
        exp_pix = (exp_pix + 1) % NPIX;
    endtask

    task automatic cfg_write(input int addr, input logic [31:0] data, input logic exp_err);
        cfg_we   = 1'b1;
        cfg_addr = 5'(addr);
        cfg_data = data;
        step();
        cfg_we = 1'b0;
        check($sformatf("cfg_err_a%0d", addr), cfg_err, exp_err);
        if (!exp_err) begin
            if (addr % 5 == 4) mb[addr / 5] = data;
            else mw[addr / 5][addr % 5] = data;
        end
    endtask

    task automatic send(input logic [127:0] px, input logic push, input logic collide);
        int n = 0;
        while (!in_ready && n < 200) begin
            step();
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got 0 want 1 within 200 cycles");
            return;
        end
        in_valid = 1'b1;
        in_data  = px;
        if (collide) begin
            cfg_we   = 1'b1;
            cfg_addr = 5'd1;
            cfg_data = 32'd77;
        end
        step();
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        if (collide) check("cfg_err_collide", cfg_err, 1'b1);
        if (push) push_exp(px);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || out_valid) && n < 500) begin
            step();
            n++;
        end
        check("drain_queue_empty", q.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %h want no output", out_data);
            end else begin
                e = q.pop_front();
                check("out_data", out_data, e.data);
                check("out_last", out_last, e.last);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] d0;
        logic [127:0] px;
        int n;
        int bad;

        model_clear();
        // Reset state
        rst = 1'b1;
        step();
        step();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_cfg_err", cfg_err, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        rst = 1'b0;
        step();
        check("post_rst_in_ready", in_ready, 1'b1);

        // Scenario 1: unit weights, biases 1..4, latency
        for (int o = 0; o < 4; o++) begin
            for (int i = 0; i < 4; i++) cfg_write(o * 5 + i, 32'd1, 1'b0);
            cfg_write(o * 5 + 4, 32'(o + 1), 1'b0);
        end
        send(pack4(1, 2, 3, 4), 1'b1, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            step();
            check($sformatf("s1_latency_edge%0d", k), out_valid, (k == 5));
        end
        step();
        check("s1_valid_one_cycle", out_valid, 1'b0);
        check("s1_golden_sum", model(pack4(1, 2, 3, 4)), pack4(11, 12, 13, 14));

        // Scenario 2: back-pressure
        out_ready = 1'b0;
        send(pack4(1, 2, 3, 4), 1'b1, 1'b0);
        n = 0;
        while (!out_valid && n < 50) begin
            step();
            n++;
        end
        check("s2_valid_rise", out_valid, 1'b1);
        d0 = out_data;
        for (int k = 0; k < 10; k++) begin
            in_valid = k[0];
            in_data  = pack4(9, 9, 9, 9);
            step();
            check("s2_in_ready_low", in_ready, 1'b0);
            check("s2_valid_held", out_valid, 1'b1);
            check("s2_data_stable", out_data, d0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("s2_in_ready_after_hs", in_ready, 1'b1);
        check("s2_valid_drop", out_valid, 1'b0);

        // Scenario 3: saturation and sign
        cfg_write(0, 32'h7fff_ffff, 1'b0);
        cfg_write(5, 32'hffff_ffff, 1'b0);
        cfg_write(9, 32'd0, 1'b0);
        cfg_write(10, 32'h8000_0000, 1'b0);
        send(pack4(2, 0, 0, 0), 1'b1, 1'b0);
        send(pack4(5, 0, 0, 0), 1'b1, 1'b0);
        drain();
`ifdef CONV1X1_RELU_EN
        check("s3_out1_ref", model(pack4(5, 0, 0, 0)) >> 32 & 128'hffff_ffff, 128'h0);
`else
        check("s3_out1_ref", model(pack4(5, 0, 0, 0)) >> 32 & 128'hffff_ffff, 128'hffff_fffb);
`endif

        // Scenario 4: random weights, 10 pixels, random stalls, frame wrap
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_clear();
        for (int a = 0; a < 20; a++) cfg_write(a, rnd_word(), 1'b0);
        fork
            begin
                for (int p = 0; p < 10; p++) send(pack4(rnd_word(), rnd_word(), rnd_word(), rnd_word()), 1'b1, 1'b0);
            end
            begin
                repeat (60) begin
                    out_ready = 1'($urandom_range(0, 1));
                    step();
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Scenario 5: reset mid-computation clears weights
        px = pack4(3, 1, 4, 1);
        send(px, 1'b0, 1'b0);
        step();
        step();
        rst = 1'b1;
        step();
        check("s5_rst_in_ready", in_ready, 1'b0);
        check("s5_rst_out_valid", out_valid, 1'b0);
        rst = 1'b0;
        model_clear();
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (out_valid) bad++;
        end
        check("s5_no_valid_cycles", bad, 0);
        check("s5_in_ready", in_ready, 1'b1);
        send(px, 1'b1, 1'b0);
        drain();

        // Scenario 6: cfg writes outside IDLE, out of range and colliding with accept
        for (int a = 0; a < 20; a++) cfg_write(a, $urandom_range(0, 20) - 10, 1'b0);
        px = pack4(7, -3, 2, 5);
        send(px, 1'b1, 1'b0);
        cfg_write(0, 32'd9, 1'b1);
        step();
        check("s6_err_pulse_width", cfg_err, 1'b0);
        drain();
        cfg_write(0, 32'd9, 1'b0);
        cfg_write(20, 32'd5, 1'b1);
        cfg_write(31, 32'd5, 1'b1);
        send(px, 1'b1, 1'b1);
        drain();
        send(pack4(1, 1, 1, 1), 1'b1, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
